// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg
// Shared types and helpers for the programming-data write sequencer.
//   state_t           : sequencer FSM states
//   TERM_BYTE_DEFAULT : default terminator command byte
//   FLD_*             : named field indices (FLD_TERM is the terminator slot)
//   field_slice()     : extracts field idx of width dw from a packed field bus
package prog_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TERM_BYTE_DEFAULT = 8'hF0;

    localparam int FLD_SEG    = 0;
    localparam int FLD_MIN    = 1;
    localparam int FLD_HORA   = 2;
    localparam int FLD_DAY    = 3;
    localparam int FLD_MONTH  = 4;
    localparam int FLD_YEAR   = 5;
    localparam int FLD_SEG_T  = 6;
    localparam int FLD_MIN_T  = 7;
    localparam int FLD_HORA_T = 8;
    localparam int FLD_TERM   = 9;

    // The helper works on a fixed-size bus so it can serve any DW/NCH that
    // fits; callers zero-extend their packed fields into it and truncate the
    // result back to DW. NCH*DW must not exceed FS_BUS_W, DW not FS_MAX_DW.
    localparam int unsigned FS_MAX_DW     = 32;
    localparam int unsigned FS_MAX_FIELDS = 16;
    localparam int unsigned FS_BUS_W      = FS_MAX_DW * FS_MAX_FIELDS;
    localparam int unsigned FS_DW_IW      = 5;   // clog2(FS_MAX_DW)
    localparam int unsigned FS_BUS_IW     = 9;   // clog2(FS_BUS_W)

    function automatic logic [FS_MAX_DW-1:0] field_slice(
        input logic [FS_BUS_W-1:0] bus,
        input int unsigned         idx,
        input int unsigned         dw
    );
        logic [FS_MAX_DW-1:0] res;
        int unsigned          pos;
        res = '0;
        for (int unsigned b = 0; b < FS_MAX_DW; b++) begin
            pos = idx * dw + b;
            if ((b < dw) && (pos < FS_BUS_W)) begin
                res[b[FS_DW_IW-1:0]] = bus[pos[FS_BUS_IW-1:0]];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prog_prio_enc.sv
// prog_prio_enc
// Lowest-set-bit priority encoder.
//   i_req   [NCH]  : request vector
//   o_idx   [SELW] : index of the lowest set bit (0 when none set)
//   o_valid        : at least one bit of i_req is set
module prog_prio_enc #(
    parameter int NCH  = 9,
    parameter int SELW = 4
) (
    input  logic [NCH-1:0]  i_req,
    output logic [SELW-1:0] o_idx,
    output logic            o_valid
);

    // Scan from the top down so the last (lowest) hit wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = SELW'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_write_sequencer.sv
// prog_write_sequencer
// Snapshots NCH programming fields on start, then writes every field enabled
// in ch_mask (lowest index first) to the RTC bus controller over a wr_req /
// wr_ack handshake, optionally followed by a terminator command byte.
//   clk, reset        : clock, synchronous active-high reset
//   start, abort      : begin / cancel a sequence
//   ch_mask [NCH]     : field enables, captured with start
//   data_in [NCH*DW]  : packed fields, captured with start
//   wr_ack            : bus controller accepted the presented byte
//   wr_req            : Data_WR / sel_prog valid, awaiting wr_ack
//   Data_WR [DW]      : byte being written
//   sel_prog [SELW]   : field index; NCH denotes the terminator
//   busy, done        : sequence in progress / one-cycle completion pulse
module prog_write_sequencer
    import prog_seq_pkg::*;
#(
    parameter int         DW        = 8,
    parameter int         NCH       = 9,
    parameter int         SELW      = 4,   // 2**SELW must exceed NCH
    parameter int         TERM_EN   = 1,
    parameter logic [7:0] TERM_BYTE = TERM_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH-1:0]    ch_mask,
    input  logic [NCH*DW-1:0] data_in,
    input  logic              wr_ack,
    output logic              wr_req,
    output logic [DW-1:0]     Data_WR,
    output logic [SELW-1:0]   sel_prog,
    output logic              busy,
    output logic              done
);

    localparam logic [DW-1:0]   TERM_DATA = DW'(TERM_BYTE);
    localparam logic [SELW-1:0] TERM_SEL  = SELW'(NCH);

    state_t              r_state, r_state_next;
    logic [NCH*DW-1:0]   r_snapshot, r_snapshot_next;
    logic [NCH-1:0]      r_pending, r_pending_next;
    logic                r_term_sent, r_term_sent_next;
    logic                r_wr_req, r_wr_req_next;
    logic [DW-1:0]       r_data, r_data_next;
    logic [SELW-1:0]     r_sel, r_sel_next;
    logic                r_busy, r_busy_next;
    logic                r_done, r_done_next;

    logic [SELW-1:0]     w_idx;
    logic                w_any;
    logic [FS_BUS_W-1:0] w_snap_ext;
    logic [FS_MAX_DW-1:0] w_field_wide;
    logic [DW-1:0]       w_field;
    logic [NCH-1:0]      w_sel_onehot;

    prog_prio_enc #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_prio_enc (
        .i_req   (r_pending),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    always_comb begin
        w_snap_ext               = '0;
        w_snap_ext[NCH*DW-1:0]   = r_snapshot;
    end

    assign w_field_wide = field_slice(w_snap_ext, int'(w_idx), DW);
    assign w_field      = w_field_wide[DW-1:0];

    // One-hot of the field currently on the bus; never matches the
    // terminator index, so acking the terminator leaves pending untouched.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_onehot
            assign w_sel_onehot[gi] = (r_sel == SELW'(gi));
        end
    endgenerate

    always_comb begin
        r_state_next     = r_state;
        r_snapshot_next  = r_snapshot;
        r_pending_next   = r_pending;
        r_term_sent_next = r_term_sent;
        r_wr_req_next    = r_wr_req;
        r_data_next      = r_data;
        r_sel_next       = r_sel;
        r_busy_next      = r_busy;
        r_done_next      = 1'b0;

        if (abort && (r_state != ST_IDLE)) begin
            // Data_WR / sel_prog deliberately keep their last values.
            r_state_next     = ST_IDLE;
            r_wr_req_next    = 1'b0;
            r_busy_next      = 1'b0;
            r_pending_next   = '0;
            r_term_sent_next = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_snapshot_next  = data_in;
                        r_pending_next   = ch_mask;
                        r_term_sent_next = 1'b0;
                        r_busy_next      = 1'b1;
                        r_state_next     = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_any) begin
                        r_sel_next    = w_idx;
                        r_data_next   = w_field;
                        r_wr_req_next = 1'b1;
                        r_state_next  = ST_REQ;
                    end else if ((TERM_EN != 0) && !r_term_sent) begin
                        r_sel_next    = TERM_SEL;
                        r_data_next   = TERM_DATA;
                        r_wr_req_next = 1'b1;
                        r_state_next  = ST_REQ;
                    end else begin
                        r_done_next  = 1'b1;
                        r_busy_next  = 1'b0;
                        r_state_next = ST_DONE;
                    end
                end
                ST_REQ: begin
                    if (wr_ack) begin
                        if (r_sel == TERM_SEL) begin
                            r_term_sent_next = 1'b1;
                        end
                        r_pending_next = r_pending & ~w_sel_onehot;
                        r_wr_req_next  = 1'b0;
                        r_state_next   = ST_SCAN;
                    end
                end
                ST_DONE: begin
                    r_state_next = ST_IDLE;
                end
                default: begin
                    r_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_snapshot  <= '0;
            r_pending   <= '0;
            r_term_sent <= 1'b0;
            r_wr_req    <= 1'b0;
            r_data      <= '0;
            r_sel       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_snapshot  <= r_snapshot_next;
            r_pending   <= r_pending_next;
            r_term_sent <= r_term_sent_next;
            r_wr_req    <= r_wr_req_next;
            r_data      <= r_data_next;
            r_sel       <= r_sel_next;
            r_busy      <= r_busy_next;
            r_done      <= r_done_next;
        end
    end

    assign wr_req   = r_wr_req;
    assign Data_WR  = r_data;
    assign sel_prog = r_sel;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_prog_write_sequencer.sv
// Scoreboard bench: the main process pushes the writes each sequence must
// produce; a monitor pops and compares on every accepted handshake.
module tb_prog_write_sequencer;

    localparam int DW   = 8;
    localparam int NCH  = 9;
    localparam int SELW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0, abort = 1'b0, wr_ack = 1'b0;
    logic              start0 = 1'b0, abort0 = 1'b0, wr_ack0 = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic [NCH*DW-1:0] data_in = '0;
    logic              wr_req, busy, done;
    logic [DW-1:0]     Data_WR;
    logic [SELW-1:0]   sel_prog;
    logic              wr_req0, busy0, done0;
    logic [DW-1:0]     Data_WR0;
    logic [SELW-1:0]   sel_prog0;

    prog_write_sequencer #(.DW(DW), .NCH(NCH), .SELW(SELW), .TERM_EN(1), .TERM_BYTE(8'hF0)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .ch_mask(ch_mask),
        .data_in(data_in), .wr_ack(wr_ack), .wr_req(wr_req), .Data_WR(Data_WR),
        .sel_prog(sel_prog), .busy(busy), .done(done));

    prog_write_sequencer #(.DW(DW), .NCH(NCH), .SELW(SELW), .TERM_EN(0), .TERM_BYTE(8'hF0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0), .ch_mask(ch_mask),
        .data_in(data_in), .wr_ack(wr_ack0), .wr_req(wr_req0), .Data_WR(Data_WR0),
        .sel_prog(sel_prog0), .busy(busy0), .done(done0));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SELW-1:0] sel;
        logic [DW-1:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  ack_delay = 0;
    logic ack_auto = 1'b1;
    logic manual_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NCH*DW-1:0] fields(input logic [DW-1:0] base);
        logic [NCH*DW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*DW +: DW] = base + DW'(i);
        return v;
    endfunction

    task automatic push(input int sel, input logic [DW-1:0] data);
        wr_t w;
        w.sel  = SELW'(sel);
        w.data = data;
        exp_q.push_back(w);
    endtask

    // Responder: acks the (ack_delay+1)-th cycle of each request.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (ack_auto && wr_req) begin
                if (cnt >= ack_delay) begin
                    wr_ack = 1'b1;
                    cnt = 0;
                end else begin
                    wr_ack = 1'b0;
                    cnt++;
                end
            end else begin
                wr_ack = ack_auto ? 1'b0 : manual_ack;
                cnt = 0;
            end
        end
    end

    // Monitor: samples late in the low phase, after all drivers settled.
    initial begin
        logic            prev_hold;
        logic [DW-1:0]   prev_data;
        logic [SELW-1:0] prev_sel;
        wr_t             w;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_sel  = '0;
        forever begin
            @(negedge clk);
            #3;
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && wr_req) begin
                    check("hold_data", 32'(Data_WR), 32'(prev_data));
                    check("hold_sel", 32'(sel_prog), 32'(prev_sel));
                end
                if (wr_req && wr_ack && !abort) begin
                    $display("write sel=%0d data=%02h", sel_prog, Data_WR);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: got sel=%0d data=%02h, expected none", sel_prog, Data_WR);
                    end else begin
                        n_checks--;
                        w = exp_q.pop_front();
                        check("write_sel", 32'(sel_prog), 32'(w.sel));
                        check("write_data", 32'(Data_WR), 32'(w.data));
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("busy_in_done", 32'(busy), 32'd0);
                end
                prev_hold = wr_req && !wr_ack && !abort;
                prev_data = Data_WR;
                prev_sel  = sel_prog;
            end
        end
    end

    // Issues start at edge t; returns at t+1 (1 time unit after the edge).
    task automatic start_seq(input logic [NCH-1:0] m, input logic [NCH*DW-1:0] d);
        @(negedge clk);
        ch_mask = m;
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int cyc0, input int max_cyc, output int done_cyc);
        int cyc;
        cyc = cyc0;
        while (!done && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within %0d cycles", max_cyc);
        end
        done_cyc = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        int dcnt0;
        // --- reset state ---
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_data", 32'(Data_WR), 32'd0);
        check("rst_sel", 32'(sel_prog), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // --- test 1 + 4: all fields, ack after 2 cycles, mid-run changes ---
        ack_delay = 2;
        dcnt0 = done_cnt;
        for (int i = 0; i < NCH; i++) push(i, 8'h10 + 8'(i));
        push(NCH, 8'hF0);
        start_seq(9'h1FF, fields(8'h10));
        repeat (6) @(negedge clk);
        data_in = fields(8'h77);
        ch_mask = 9'h003;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_done(0, 200, dc);
        @(posedge clk);
        #1;
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_done_after", 32'(done), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("t1_no_restart", 32'(busy), 32'd0);
        check("t1_done_count", 32'(done_cnt - dcnt0), 32'd1);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // --- test 2: two fields + terminator, immediate ack ---
        ack_delay = 0;
        push(1, 8'hA1);
        push(4, 8'hA4);
        push(NCH, 8'hF0);
        start_seq(9'b000010010, fields(8'hA0));
        check("t2_req_t1", 32'(wr_req), 32'd0);
        @(posedge clk);
        #1;
        check("t2_req_t2", 32'(wr_req), 32'd1);
        check("t2_sel_t2", 32'(sel_prog), 32'd1);
        check("t2_data_t2", 32'(Data_WR), 32'hA1);
        @(posedge clk);
        #1;
        check("t2_req_low_a1", 32'(wr_req), 32'd0);
        wait_done(3, 50, dc);
        check("t2_done_cycle", 32'(dc), 32'd8);
        repeat (2) @(posedge clk);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // --- test 3a: empty mask, terminator only ---
        push(NCH, 8'hF0);
        start_seq('0, fields(8'h55));
        wait_done(1, 50, dc);
        check("t3a_done_cycle", 32'(dc), 32'd4);
        repeat (2) @(posedge clk);
        check("t3a_queue_empty", 32'(exp_q.size()), 32'd0);

        // --- test 3b: empty mask, no terminator ---
        @(negedge clk);
        ch_mask = '0;
        start0  = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        check("t3b_busy_t1", 32'(busy0), 32'd1);
        check("t3b_done_t1", 32'(done0), 32'd0);
        @(posedge clk);
        #1;
        check("t3b_done_t2", 32'(done0), 32'd1);
        check("t3b_busy_t2", 32'(busy0), 32'd0);
        check("t3b_req_t2", 32'(wr_req0), 32'd0);
        @(posedge clk);
        #1;
        check("t3b_done_t3", 32'(done0), 32'd0);

        // --- test 5: abort with the third ack ---
        dcnt0 = done_cnt;
        push(0, 8'h30);
        push(1, 8'h31);
        start_seq(9'h1FF, fields(8'h30));
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("t5_req_after_abort", 32'(wr_req), 32'd0);
        check("t5_busy_after_abort", 32'(busy), 32'd0);
        check("t5_sel_hold", 32'(sel_prog), 32'd2);
        check("t5_data_hold", 32'(Data_WR), 32'h32);
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_done", 32'(done_cnt - dcnt0), 32'd0);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NCH; i++) push(i, 8'h40 + 8'(i));
        push(NCH, 8'hF0);
        start_seq(9'h1FF, fields(8'h40));
        wait_done(1, 100, dc);
        check("t5_rerun_done_cycle", 32'(dc), 32'd22);
        repeat (2) @(posedge clk);
        check("t5_rerun_queue_empty", 32'(exp_q.size()), 32'd0);

        // --- test 6: reset in REQ ---
        ack_delay = 2;
        push(0, 8'h60);
        start_seq(9'b000000101, fields(8'h60));
        @(posedge clk);
        #1;
        check("t6_in_req", 32'(wr_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("t6_rst_req", 32'(wr_req), 32'd0);
        check("t6_rst_data", 32'(Data_WR), 32'd0);
        check("t6_rst_sel", 32'(sel_prog), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        ack_auto = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            manual_ack = (i % 2 == 0);
            check("t6_idle_req", 32'(wr_req), 32'd0);
            check("t6_idle_busy", 32'(busy), 32'd0);
        end
        manual_ack = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
